// File: rtl/ncl_pkg.sv
// Dual-rail NCL constants, FSM encoding and rail-pair helpers
// shared by the synchronous add/subtract wrapper and its core.
package ncl_pkg;

    localparam logic [1:0] DR_NULL = 2'b00;
    localparam logic [1:0] DR_F    = 2'b01;
    localparam logic [1:0] DR_T    = 2'b10;
    localparam logic [1:0] DR_INV  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        NUL  = 2'd2
    } state_e;

    function automatic logic [1:0] dr_enc(input logic b);
        return b ? DR_T : DR_F;
    endfunction

    // Only meaningful on a completed pair; the true rail carries the value.
    function automatic logic dr_dec(input logic [1:0] p);
        return p[1] & ~p[0];
    endfunction

    function automatic logic dr_done(input logic [1:0] p);
        return (p == DR_T) || (p == DR_F);
    endfunction

    function automatic logic dr_inv(input logic [1:0] p);
        return p == DR_INV;
    endfunction

endpackage

// File: rtl/ncl_addsub_core.sv
// Combinational dual-rail ripple adder; NULL in gives NULL out,
// an invalid rail pair anywhere upstream poisons everything downstream.
module ncl_addsub_core
    import ncl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] a_dr,
    input  logic [2*WIDTH-1:0] b_dr,
    input  logic [1:0]         cin_dr,
    output logic [2*WIDTH-1:0] sum_dr,
    output logic [1:0]         cout_dr,
    output logic [1:0]         ovf_dr
);

    function automatic logic [3:0] full_adder(
        input logic [1:0] a,
        input logic [1:0] b,
        input logic [1:0] c
    );
        logic s;
        logic co;
        if (dr_inv(a) || dr_inv(b) || dr_inv(c))
            return {DR_INV, DR_INV};
        if (!(dr_done(a) && dr_done(b) && dr_done(c)))
            return {DR_NULL, DR_NULL};
        s  = dr_dec(a) ^ dr_dec(b) ^ dr_dec(c);
        co = (dr_dec(a) & dr_dec(b))
           | (dr_dec(c) & (dr_dec(a) ^ dr_dec(b)));
        return {dr_enc(co), dr_enc(s)};
    endfunction

    function automatic logic [1:0] ncl_xor(
        input logic [1:0] x,
        input logic [1:0] y
    );
        if (dr_inv(x) || dr_inv(y))
            return DR_INV;
        if (!(dr_done(x) && dr_done(y)))
            return DR_NULL;
        return dr_enc(dr_dec(x) ^ dr_dec(y));
    endfunction

    logic [1:0] c [WIDTH+1];

    always_comb begin
        sum_dr = '0;
        c[0]   = cin_dr;
        for (int i = 0; i < WIDTH; i++) begin
            {c[i+1], sum_dr[2*i +: 2]} =
                full_adder(a_dr[2*i +: 2], b_dr[2*i +: 2], c[i]);
        end
    end

    assign cout_dr = c[WIDTH];
    assign ovf_dr  = ncl_xor(c[WIDTH-1], c[WIDTH]);

endmodule

// File: rtl/ncl_addsub_sync.sv
// Synchronous valid/ready wrapper sequencing DATA/NULL wavefronts
// through the dual-rail core, with timeout and invalid-code detection.
module ncl_addsub_sync
    import ncl_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_soma,
    output logic             out_cout,
    output logic             out_overflow,
    output logic             err
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] a_q, a_d;
    logic [2*WIDTH-1:0] b_q, b_d;
    logic [1:0]         cin_q, cin_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               vld_q, vld_d;
    logic [WIDTH-1:0]   soma_q, soma_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;

    logic [2*WIDTH-1:0] core_sum;
    logic [1:0]         core_cout;
    logic [1:0]         core_ovf;
    logic               all_done;
    logic               any_inv;
    logic               all_null;

    ncl_addsub_core #(.WIDTH(WIDTH)) u_core (
        .a_dr    (a_q),
        .b_dr    (b_q),
        .cin_dr  (cin_q),
        .sum_dr  (core_sum),
        .cout_dr (core_cout),
        .ovf_dr  (core_ovf)
    );

    assign in_ready = (state_q == IDLE) && (!vld_q || out_ready);

    always_comb begin
        all_done = dr_done(core_cout);
        any_inv  = dr_inv(core_cout) || dr_inv(core_ovf);
        all_null = (core_cout == DR_NULL) && (core_ovf == DR_NULL);
        for (int i = 0; i < WIDTH; i++) begin
            all_done = all_done && dr_done(core_sum[2*i +: 2]);
            any_inv  = any_inv || dr_inv(core_sum[2*i +: 2]);
            all_null = all_null && (core_sum[2*i +: 2] == DR_NULL);
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        soma_d  = soma_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        err_d   = err_q;

        if (vld_q && out_ready)
            vld_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        a_d[2*i +: 2] = dr_enc(in_a[i]);
                        b_d[2*i +: 2] = dr_enc(in_b[i] ^ in_mode);
                    end
                    cin_d   = dr_enc(in_cin ^ in_mode);
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (any_inv || all_done ||
                    cnt_q == CW'(TIMEOUT - 1)) begin
                    a_d     = '0;
                    b_d     = '0;
                    cin_d   = DR_NULL;
                    state_d = NUL;
                    if (!any_inv && all_done) begin
                        for (int i = 0; i < WIDTH; i++)
                            soma_d[i] = dr_dec(core_sum[2*i +: 2]);
                        cout_d = dr_dec(core_cout);
                        ovf_d  = dr_dec(core_ovf);
                        vld_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            NUL: begin
                if (all_null)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= DR_NULL;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            soma_q  <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            soma_q  <= soma_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign out_valid    = vld_q;
    assign out_soma     = soma_q;
    assign out_cout     = cout_q;
    assign out_overflow = ovf_q;
    assign err          = err_q;

endmodule

// File: doc/ncl_addsub_sync.md
Name: ncl_addsub_sync

Overview:
- Parametrised successor of the team's 8-bit NCL dual-rail ripple adder.
- Accepts single-rail operands from the synchronous CPU datapath over a valid/ready handshake and encodes them as a dual-rail DATA wavefront.
- Drives an N-bit dual-rail add/subtract core, detects DATA and NULL completion, and returns the registered result with carry, signed overflow and error status.
- Adds what the fixed adder lacks: width parameter, subtract mode, four-phase DATA/NULL sequencing, completion timeout and invalid-code detection.

Parameters:
- WIDTH, 8, operand width in bits; legal range is WIDTH >= 2.
- TIMEOUT, 16, maximum cycles spent in DATA waiting for completion before error.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands this cycle.
- in_a  in  WIDTH  operand A, single-rail.
- in_b  in  WIDTH  operand B, single-rail.
- in_mode  in  1  0 = add, 1 = subtract.
- in_cin  in  1  carry-in for add; borrow-in for subtract.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  consumer accepts the result.
- out_soma  out  WIDTH  sum or difference.
- out_cout  out  1  raw carry-out of the MSB stage; 1 = no borrow in subtract.
- out_overflow  out  1  signed overflow = carry into MSB XOR carry-out.
- err  out  1  sticky: timeout or invalid dual-rail code seen.

Behaviour:
- Dual-rail encoding per bit, {t,f}: 00 = NULL, 01 = 0, 10 = 1, 11 = invalid. Rail pair i sits at bits [2i+1:2i], true rail on the odd index.
- Effective operand/carry: b_eff = in_b XOR {WIDTH{in_mode}}; cin_eff = in_cin XOR in_mode. The core computes in_a + b_eff + cin_eff.
- FSM states: IDLE, DATA, NUL.
  - IDLE: core inputs driven NULL. in_ready = (state==IDLE) && (!out_valid || out_ready). A handshake (in_valid && in_ready) latches the encoded operands into the drive register and moves to DATA.
  - DATA: drive register presented to the core. Each cycle the combinational completion term is evaluated; it is true when every sum rail pair and the carry-out pair is non-NULL and none is 11.
    - Completion true at the edge: capture results into the out_* registers, set out_valid, go to NUL.
    - Any rail pair equal to 11: set err, go to NUL, no result.
    - Timeout counter reaches TIMEOUT-1 without completion: set err, go to NUL, no result.
  - NUL: drive register forced to NULL. When all core outputs are 00 at an edge, go to IDLE. NULL has no timeout; the core is combinationally NULL-able.
- Latency, with the core settling within one cycle: operands accepted at edge E0, out_valid high after E1, NUL during cycle E1..E2, IDLE after E2. Earliest next accept is at E3, giving one operation per 3 cycles.
- out_valid clears on out_valid && out_ready unless a new result is captured on the same edge; capture wins.
- out_* registers hold their value while out_valid=1 and out_ready=0. No new accept occurs while the result is unconsumed.
- err is sticky until rst; it does not block further operations.
- Reset, including mid-operation: state=IDLE, drive register = NULL, counter=0, out_valid=0, out_soma=0, out_cout=0, out_overflow=0, err=0. in_ready is high in the first cycle after reset release.
- Boundary cases:
  - WIDTH-bit wrap-around drops the carry into out_cout.
  - Overflow uses the carry into bit WIDTH-1.
  - in_valid held high while in_ready=0 is ignored, with no side effects.

Decomposition:
- ncl_pkg holds:
  - dual-rail constants DR_NULL=2'b00, DR_F=2'b01, DR_T=2'b10, DR_INV=2'b11;
  - FSM state encoding (IDLE/DATA/NUL);
  - encode/decode and per-pair completion functions.
- Sub-module ncl_addsub_core: purely combinational, parametrised WIDTH ripple chain of the existing full_adder cells plus NCL_xor for overflow. It uses dual-rail in/out buses of width 2*WIDTH and pass-through NULL behaviour.
- ncl_addsub_sync holds the FSM, drive register, timeout counter and output registers.

Test Plan:
- WIDTH=8, add 8'h7F + 8'h01, cin=0 -> out_soma=8'h80, out_cout=0, out_overflow=1; out_valid one cycle after accept.
- Subtract 8'h05 - 8'h07, cin=0 -> out_soma=8'hFE, out_cout=0 (borrow), out_overflow=0. Then 8'h80 - 8'h01 -> 8'h7F, out_cout=1, out_overflow=1.
- Back-to-back in_valid with out_ready=1 -> accepts spaced exactly 3 cycles. With out_ready=0 -> in_ready stays 0 and result 8'hFF (from 8'hFE + 8'h01) holds stable until out_ready rises.
- Force a rail pair to 11 in the core during DATA -> err=1 next edge, out_valid stays 0, FSM returns to IDLE via NUL. Force a stuck-NULL output -> err=1 after 16 DATA cycles.
- Assert rst asynchronously mid-DATA -> all outputs 0 immediately, in_ready=1 after release; a subsequent 8'h01 + 8'h01 gives 8'h02.
- WIDTH=16: 16'hFFFF + 16'h0001 -> out_soma=16'h0000, out_cout=1, out_overflow=0.
